line_xfer_ctrl: RTL and testbench

Sequences whole-cache-line transfers between the cache and the 32-bit word-wide memory bus. Writebacks serialize a 256-bit victim line into 8 word beats; refills deserialize 8 word beats into a 256-bit line. The block owns the single memory port and arbitrates between the writeback and refill requesters. It sits between the cache controller FSM and main memory, and replaces ad-hoc shifting with a handshaked, counted beat sequence.

---
 rtl/line_xfer_ctrl.sv | 104 ++++++++++
 tb/tb_line_xfer_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_xfer_ctrl.sv
// Cache-line transfer sequencer: serializes 256-bit writebacks and deserializes
// 256-bit refills over a handshaked 32-bit memory bus, writeback first.
module line_xfer_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [255:0]      wb_line,
  output logic              wb_done,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic [255:0]      fill_line,
  output logic              fill_done,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        cnt;
  logic [ADDR_W-6:0] base;
  logic [255:0]      snap;
  logic              was_wb;
  logic              xfer;

  // Byte offset inside the line is irrelevant to a whole-line transfer.
  logic unused_offset;
  assign unused_offset = ^{wb_addr[4:0], fill_addr[4:0]};

  assign xfer = (state == WB) || (state == FILL);

  // NOTE: always_comb assigns a default first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wb_req)        state_nxt = WB;
        else if (fill_req) state_nxt = FILL;
      end
      WB, FILL: begin
        if (mem_ready && cnt == 3'd7) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      base      <= '0;
      was_wb    <= 1'b0;
      fill_line <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (wb_req) begin
            base   <= wb_addr[ADDR_W-1:5];
            cnt    <= 3'd0;
            was_wb <= 1'b1;
          end else if (fill_req) begin
            base   <= fill_addr[ADDR_W-1:5];
            cnt    <= 3'd0;
            was_wb <= 1'b0;
          end
        end
        WB, FILL: begin
          if (mem_ready) begin
            cnt <= cnt + 3'd1;
            if (state == FILL) fill_line[32*int'(cnt) +: 32] <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the snapshot is pure datapath and never reset; its output is gated by state instead.
  always_ff @(posedge clk) begin
    if (state == IDLE && wb_req) snap <= wb_line;
    else if (state == WB && mem_ready) snap <= {32'd0, snap[255:32]};
  end

  assign busy      = (state != IDLE);
  assign mem_valid = xfer;
  assign mem_we    = (state == WB);
  assign mem_addr  = xfer ? {base, cnt, 2'b00} : '0;
  assign mem_wdata = (state == WB) ? snap[31:0] : 32'd0;
  assign wb_done   = (state == RESP) && was_wb;
  assign fill_done = (state == RESP) && !was_wb;

endmodule

// File: tb/tb_line_xfer_ctrl.sv
// Scoreboard bench for line_xfer_ctrl: stimulus pushes expected beats and done
// events; a negedge monitor pops and compares whatever the DUT presents.
module tb_line_xfer_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wb_req;
  logic [31:0]  wb_addr;
  logic [255:0] wb_line;
  logic         wb_done;
  logic         fill_req;
  logic [31:0]  fill_addr;
  logic [255:0] fill_line;
  logic         fill_done;
  logic         mem_valid;
  logic         mem_ready;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_beat = -100;
  bit toggle_ready = 1'b0;

  typedef struct {
    int           kind;   // 0 beat, 1 wb_done, 2 fill_done
    logic [31:0]  addr;
    logic         we;
    logic [31:0]  wdata;
    logic [255:0] line;
    int           cyc;    // -1 = any cycle
  } exp_t;

  exp_t sb[$];

  line_xfer_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_line(wb_line), .wb_done(wb_done),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_line(fill_line), .fill_done(fill_done),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data is a function of the word address.
  assign mem_rdata = 32'hB000_0000 + {29'd0, mem_addr[4:2]};

  always @(posedge clk) begin
    #1;
    if (toggle_ready) mem_ready = ~mem_ready;
    else              mem_ready = 1'b1;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [255:0] pattern(input logic [31:0] base_word);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base_word + i;
    return l;
  endfunction

  task automatic push_xfer(input bit is_wb, input logic [31:0] addr, input logic [255:0] line,
                           input int t0, input int nbeats);
    exp_t e;
    for (int i = 0; i < nbeats; i++) begin
      e.kind  = 0;
      e.addr  = {addr[31:5], 3'(i), 2'b00};
      e.we    = is_wb;
      e.wdata = is_wb ? line[32*i +: 32] : 32'd0;
      e.line  = '0;
      e.cyc   = (t0 < 0) ? -1 : t0 + 1 + i;
      sb.push_back(e);
    end
    if (nbeats == 8) begin
      e.kind = is_wb ? 1 : 2;
      e.addr = '0; e.we = 1'b0; e.wdata = '0;
      e.line = pattern(32'hB000_0000);
      e.cyc  = (t0 < 0) ? -1 : t0 + 9;
      sb.push_back(e);
    end
  endtask

  // Monitor: compares every accepted beat and every done pulse against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_valid && mem_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected: got addr %0h with nothing expected", mem_addr);
        end else begin
          e = sb.pop_front();
          check("beat_kind", 256'(0), 256'(e.kind));
          check("beat_addr", 256'(mem_addr), 256'(e.addr));
          check("beat_we", 256'(mem_we), 256'(e.we));
          if (e.we) check("beat_wdata", 256'(mem_wdata), 256'(e.wdata));
          if (e.cyc >= 0) check("beat_cycle", 256'(cyc), 256'(e.cyc));
        end
        last_beat = cyc;
      end
      if (wb_done || fill_done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got wb_done %0b fill_done %0b", wb_done, fill_done);
        end else begin
          e = sb.pop_front();
          check("done_kind", 256'(wb_done ? 1 : 2), 256'(e.kind));
          check("done_both", 256'(wb_done & fill_done), 256'(0));
          check("done_after_last_beat", 256'(cyc), 256'(last_beat + 1));
          if (e.cyc >= 0) check("done_cycle", 256'(cyc), 256'(e.cyc));
          if (fill_done) check("fill_line", fill_line, e.line);
        end
      end
    end
  end

  task automatic start_cycle(output int t0);
    @(posedge clk); #1;
    t0 = cyc;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy && sb.size() == 0) return;
    end
    checks++; errors++;
    $display("FAIL wait_idle: timeout, busy %0b pending %0d", busy, sb.size());
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_valid"}, 256'(mem_valid), 256'(0));
    check({tag, "_mem_we"}, 256'(mem_we), 256'(0));
    check({tag, "_mem_addr"}, 256'(mem_addr), 256'(0));
    check({tag, "_mem_wdata"}, 256'(mem_wdata), 256'(0));
    check({tag, "_fill_line"}, fill_line, 256'(0));
    check({tag, "_done"}, 256'({wb_done, fill_done}), 256'(0));
    check({tag, "_busy"}, 256'(busy), 256'(0));
  endtask

  initial begin
    int t0;
    logic [255:0] held;
    rst_n = 1'b0; wb_req = 1'b0; fill_req = 1'b0;
    wb_addr = '0; fill_addr = '0; wb_line = '0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Writeback, ready high.
    start_cycle(t0);
    wb_addr = 32'h0000_1040; wb_line = pattern(32'hA000_0000); wb_req = 1'b1;
    push_xfer(1'b1, 32'h0000_1040, pattern(32'hA000_0000), t0, 8);
    @(posedge clk); #1 wb_req = 1'b0;
    wait_idle(40);
    check("wb_idle_cycle", 256'(cyc), 256'(t0 + 10));

    // Refill with mem_ready toggling every cycle.
    toggle_ready = 1'b1;
    start_cycle(t0);
    fill_addr = 32'h0000_2000; fill_req = 1'b1;
    push_xfer(1'b0, 32'h0000_2000, '0, -1, 8);
    @(posedge clk); #1 fill_req = 1'b0;
    wait_idle(60);
    toggle_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("fill_line_hold", fill_line, pattern(32'hB000_0000));

    // Contention: writeback first, fill granted in the IDLE cycle after wb_done.
    start_cycle(t0);
    wb_addr = 32'h0000_3000; wb_line = pattern(32'h1000_0000);
    fill_addr = 32'h0000_4020; wb_req = 1'b1; fill_req = 1'b1;
    push_xfer(1'b1, 32'h0000_3000, pattern(32'h1000_0000), t0, 8);
    push_xfer(1'b0, 32'h0000_4020, '0, t0 + 10, 8);
    @(posedge clk); #1 wb_req = 1'b0;
    repeat (10) @(posedge clk);
    #1 fill_req = 1'b0;
    wait_idle(40);

    // Reset after three writeback beats: no done, then a clean restart.
    start_cycle(t0);
    wb_addr = 32'h0000_5000; wb_line = pattern(32'h5000_0000); wb_req = 1'b1;
    push_xfer(1'b1, 32'h0000_5000, pattern(32'h5000_0000), t0, 3);
    @(posedge clk); #1 wb_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    check("midreset_pending", 256'(sb.size()), 256'(0));
    repeat (3) @(posedge clk);
    start_cycle(t0);
    wb_req = 1'b1;
    push_xfer(1'b1, 32'h0000_5000, pattern(32'h5000_0000), t0, 8);
    @(posedge clk); #1 wb_req = 1'b0;
    wait_idle(40);

    // Unaligned address, request dropped and line changed mid-transfer.
    start_cycle(t0);
    wb_addr = 32'h0000_1047; wb_line = pattern(32'hC000_0000); wb_req = 1'b1;
    push_xfer(1'b1, 32'h0000_1047, pattern(32'hC000_0000), t0, 8);
    @(posedge clk); #1 wb_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 wb_line = {8{32'hDEAD_BEEF}}; wb_addr = 32'h0000_9000;
    wait_idle(40);

    // Held fill request: second fill's first beat two cycles after fill_done.
    start_cycle(t0);
    fill_addr = 32'h0000_6000; fill_req = 1'b1;
    push_xfer(1'b0, 32'h0000_6000, '0, t0, 8);
    push_xfer(1'b0, 32'h0000_6000, '0, t0 + 10, 8);
    repeat (11) @(posedge clk);
    #1 fill_req = 1'b0;
    wait_idle(40);
    held = fill_line;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("fill_line_final", fill_line, held);
    check("final_busy", 256'(busy), 256'(0));
    check("final_pending", 256'(sb.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
